// File: rtl/cache_bus_arbiter.sv
// Shared-bus arbiter for four cores (DL + IL ports each): round-robin processor
// grant, with one nested snoop grant (cache or memory) under the current owner.
module cache_bus_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Com_Bus_Req_proc,
  input  logic [7:0] Com_Bus_Req_snoop,
  input  logic       Mem_snoop_req,
  output logic [7:0] Com_Bus_Gnt_proc,
  output logic [7:0] Com_Bus_Gnt_snoop,
  output logic       Mem_snoop_gnt,
  output logic [2:0] Bus_owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROC  = 2'd1,
    SNOOP = 2'd2
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit at or above ptr, wrapping 7->0.
  function automatic pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    pick_t      res;
    logic [2:0] idx;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!res.found && req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] gnt_proc_q, gnt_proc_d;
  logic [7:0] gnt_snoop_q, gnt_snoop_d;
  logic       mem_gnt_q, mem_gnt_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] snoop_ptr_q, snoop_ptr_d;
  logic [2:0] snoop_idx_q, snoop_idx_d;
  logic       ready_q;

  pick_t      proc_pick;
  pick_t      snoop_pick;
  logic [7:0] snoop_elig;
  logic       owner_req;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    gnt_proc_d  = gnt_proc_q;
    gnt_snoop_d = gnt_snoop_q;
    mem_gnt_d   = mem_gnt_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    snoop_ptr_d = snoop_ptr_q;
    snoop_idx_d = snoop_idx_q;

    proc_pick  = rr_pick(Com_Bus_Req_proc, rr_ptr_q);
    // The owner's one-hot grant masks its own snoop request out of contention.
    snoop_elig = Com_Bus_Req_snoop & ~gnt_proc_q;
    snoop_pick = rr_pick(snoop_elig, snoop_ptr_q);
    owner_req  = Com_Bus_Req_proc[owner_q];

    unique case (state_q)
      IDLE: begin
        if (ready_q && proc_pick.found) begin
          state_d    = PROC;
          gnt_proc_d = 8'(1) << proc_pick.idx;
          owner_d    = proc_pick.idx;
        end
      end

      PROC: begin
        if (!owner_req) begin
          state_d     = IDLE;
          gnt_proc_d  = '0;
          gnt_snoop_d = '0;
          mem_gnt_d   = 1'b0;
          rr_ptr_d    = owner_q + 3'd1;
        end else if (snoop_pick.found) begin
          state_d     = SNOOP;
          gnt_snoop_d = 8'(1) << snoop_pick.idx;
          snoop_idx_d = snoop_pick.idx;
        end else if (Mem_snoop_req) begin
          state_d   = SNOOP;
          mem_gnt_d = 1'b1;
        end
      end

      SNOOP: begin
        // Owner release wins over any outstanding snoop activity.
        if (!owner_req) begin
          state_d     = IDLE;
          gnt_proc_d  = '0;
          gnt_snoop_d = '0;
          mem_gnt_d   = 1'b0;
          rr_ptr_d    = owner_q + 3'd1;
        end else if (mem_gnt_q) begin
          if (!Mem_snoop_req) begin
            state_d   = PROC;
            mem_gnt_d = 1'b0;
          end
        end else if (!Com_Bus_Req_snoop[snoop_idx_q]) begin
          state_d     = PROC;
          gnt_snoop_d = '0;
          snoop_ptr_d = snoop_idx_q + 3'd1;
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_proc_d  = '0;
        gnt_snoop_d = '0;
        mem_gnt_d   = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_proc_q  <= '0;
      gnt_snoop_q <= '0;
      mem_gnt_q   <= 1'b0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      snoop_ptr_q <= '0;
      snoop_idx_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_proc_q  <= gnt_proc_d;
      gnt_snoop_q <= gnt_snoop_d;
      mem_gnt_q   <= mem_gnt_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      snoop_ptr_q <= snoop_ptr_d;
      snoop_idx_q <= snoop_idx_d;
      // Holds off the first grant until the second edge after reset release.
      ready_q     <= 1'b1;
    end
  end

  assign Com_Bus_Gnt_proc  = gnt_proc_q;
  assign Com_Bus_Gnt_snoop = gnt_snoop_q;
  assign Mem_snoop_gnt     = mem_gnt_q;
  assign Bus_owner         = owner_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: directed scenarios through a
// scoreboard queue, then random stimulus with invariant and starvation checks.
module tb_cache_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_proc;
  logic [7:0] req_snoop;
  logic       mem_req;
  logic [7:0] gnt_proc;
  logic [7:0] gnt_snoop;
  logic       mem_gnt;
  logic [2:0] bus_owner;

  cache_bus_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .Com_Bus_Req_proc  (req_proc),
    .Com_Bus_Req_snoop (req_snoop),
    .Mem_snoop_req     (mem_req),
    .Com_Bus_Gnt_proc  (gnt_proc),
    .Com_Bus_Gnt_snoop (gnt_snoop),
    .Mem_snoop_gnt     (mem_gnt),
    .Bus_owner         (bus_owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] gp;
    logic [7:0] gs;
    logic       mg;
    logic [2:0] own;
    bit         chk_own;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push(input string name, input logic [7:0] gp, input logic [7:0] gs,
                      input logic mg, input logic [2:0] own, input bit chk_own);
    exp_t e;
    e.name = name; e.gp = gp; e.gs = gs; e.mg = mg; e.own = own; e.chk_own = chk_own;
    sb_q.push_back(e);
  endtask

  // Advance one edge, then pop the oldest expectation and compare.
  task automatic step_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty: got no expectation, required one");
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if (gnt_proc !== e.gp || gnt_snoop !== e.gs || mem_gnt !== e.mg ||
          (e.chk_own && bus_owner !== e.own))
        $display("FAIL %s: got gp=%h gs=%h mg=%b own=%0d, required gp=%h gs=%h mg=%b own=%0d",
                 e.name, gnt_proc, gnt_snoop, mem_gnt, bus_owner, e.gp, e.gs, e.mg, e.own);
      else
        n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_proc = '0; req_snoop = '0; mem_req = 1'b0;
    push("reset_a", 8'h00, 8'h00, 1'b0, 3'd0, 1'b1); step_check();
    push("reset_b", 8'h00, 8'h00, 1'b0, 3'd0, 1'b1); step_check();
    rst = 1'b0;
    push("reset_release", 8'h00, 8'h00, 1'b0, 3'd0, 1'b1); step_check();
  endtask

  task automatic test_simultaneous();
    req_proc = 8'hFF;
    push("simul_first", 8'h01, 8'h00, 1'b0, 3'd0, 1'b1); step_check();
    req_proc = 8'hFE;
    push("simul_gap", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0); step_check();
    push("simul_next", 8'h02, 8'h00, 1'b0, 3'd1, 1'b1); step_check();
    req_proc = 8'h00;
    push("simul_release", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0); step_check();
  endtask

  task automatic test_wrap();
    req_proc = 8'h40;
    push("wrap_owner6", 8'h40, 8'h00, 1'b0, 3'd6, 1'b1); step_check();
    req_proc = 8'h82;
    push("wrap_gap", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0); step_check();
    push("wrap_bit7", 8'h80, 8'h00, 1'b0, 3'd7, 1'b1); step_check();
    req_proc = 8'h02;
    push("wrap_gap2", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0); step_check();
    push("wrap_bit1", 8'h02, 8'h00, 1'b0, 3'd1, 1'b1); step_check();
    req_proc = 8'h00;
    push("wrap_release", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0); step_check();
  endtask

  task automatic test_snoop();
    req_proc = 8'h04;
    push("snoop_owner2", 8'h04, 8'h00, 1'b0, 3'd2, 1'b1); step_check();
    req_snoop = 8'h05; mem_req = 1'b1;
    push("snoop_grant0", 8'h04, 8'h01, 1'b0, 3'd2, 1'b1); step_check();
    push("snoop_hold", 8'h04, 8'h01, 1'b0, 3'd2, 1'b1); step_check();
    req_snoop = 8'h04;
    push("snoop_release", 8'h04, 8'h00, 1'b0, 3'd2, 1'b1); step_check();
    push("snoop_self_mem", 8'h04, 8'h00, 1'b1, 3'd2, 1'b1); step_check();
    push("mem_hold", 8'h04, 8'h00, 1'b1, 3'd2, 1'b1); step_check();
    mem_req = 1'b0;
    push("mem_release", 8'h04, 8'h00, 1'b0, 3'd2, 1'b1); step_check();
    req_proc = 8'h00; req_snoop = 8'h00;
    push("snoop_owner_done", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0); step_check();
  endtask

  task automatic test_idle_snoop_pending();
    req_snoop = 8'hFF; mem_req = 1'b1;
    push("idle_snoop_a", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0); step_check();
    push("idle_snoop_b", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0); step_check();
    req_snoop = 8'h00; mem_req = 1'b0;
  endtask

  task automatic test_owner_abort();
    // rr_ptr is 3 and snoop_ptr is 1 at this point.
    req_proc = 8'h08;
    push("abort_owner3", 8'h08, 8'h00, 1'b0, 3'd3, 1'b1); step_check();
    req_snoop = 8'h10;
    push("abort_snoop4", 8'h08, 8'h10, 1'b0, 3'd3, 1'b1); step_check();
    req_proc = 8'h00;
    push("abort_clear", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0); step_check();
    push("abort_idle", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0); step_check();
    req_snoop = 8'h00;
  endtask

  task automatic test_reset_mid();
    // rr_ptr is 4, so owner 6 is the first requester found.
    req_proc = 8'h40;
    push("rstmid_owner6", 8'h40, 8'h00, 1'b0, 3'd6, 1'b1); step_check();
    mem_req = 1'b1;
    push("rstmid_mem", 8'h40, 8'h00, 1'b1, 3'd6, 1'b1); step_check();
    rst = 1'b1; req_proc = 8'hFF;
    push("rstmid_clear", 8'h00, 8'h00, 1'b0, 3'd0, 1'b1); step_check();
    rst = 1'b0;
    push("rstmid_holdoff", 8'h00, 8'h00, 1'b0, 3'd0, 1'b1); step_check();
    push("rstmid_grant0", 8'h01, 8'h00, 1'b0, 3'd0, 1'b1); step_check();
    req_proc = 8'h00; mem_req = 1'b0;
    push("rstmid_release", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0); step_check();
  endtask

  task automatic test_random();
    int         wait_cnt [8];
    logic [7:0] prev_gp;
    logic [7:0] snoop_any;
    bit         new_grant;
    bit         bad;
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    prev_gp = gnt_proc;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      @(posedge clk);
      #1;
      snoop_any = gnt_snoop;
      bad = !$onehot0(gnt_proc) || !$onehot0({snoop_any, mem_gnt}) ||
            ((|snoop_any || mem_gnt) && gnt_proc == 8'h00) ||
            (gnt_proc != 8'h00 && gnt_proc[bus_owner] !== 1'b1);
      n_checks++;
      if (bad)
        $display("FAIL invariant cycle %0d: got gp=%h gs=%h mg=%b own=%0d, required one-hot-or-zero grants with owner bit set",
                 cyc, gnt_proc, gnt_snoop, mem_gnt, bus_owner);
      else
        n_pass++;

      new_grant = (gnt_proc != 8'h00) && (prev_gp == 8'h00);
      if (new_grant) begin
        for (int i = 0; i < 8; i++) begin
          if (gnt_proc[i]) wait_cnt[i] = 0;
          else if (req_proc[i]) begin
            wait_cnt[i]++;
            n_checks++;
            if (wait_cnt[i] > 8)
              $display("FAIL starvation bit %0d: got %0d grants to others while waiting, required at most 8",
                       i, wait_cnt[i]);
            else
              n_pass++;
          end
        end
      end
      prev_gp = gnt_proc;

      for (int i = 0; i < 8; i++) begin
        if (gnt_proc[i]) begin
          if ($urandom_range(0, 5) == 0) req_proc[i] = 1'b0;
        end else if (req_proc[i]) begin
          if ($urandom_range(0, 49) == 0) begin
            req_proc[i] = 1'b0;
            wait_cnt[i] = 0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req_proc[i] = 1'b1;
          wait_cnt[i] = 0;
        end
        if (gnt_snoop[i]) begin
          if ($urandom_range(0, 3) == 0) req_snoop[i] = 1'b0;
        end else begin
          req_snoop[i] = ($urandom_range(0, 9) == 0);
        end
      end
      if (mem_gnt) begin
        if ($urandom_range(0, 3) == 0) mem_req = 1'b0;
      end else begin
        mem_req = ($urandom_range(0, 4) == 0);
      end
    end
    req_proc = '0; req_snoop = '0; mem_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_proc = '0; req_snoop = '0; mem_req = 1'b0;
    @(negedge clk);
    test_reset();
    test_simultaneous();
    test_wrap();
    test_snoop();
    test_idle_snoop_pending();
    test_owner_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
